// File: rtl/hdmi_period_scheduler_pkg.sv
// Shared types and constants for HDMI period sequencing: period states,
// default preamble/guard lengths, guard-band symbols and the video preamble CTL pattern.
package hdmi_period_scheduler_pkg;

   typedef enum logic [1:0] {
      PER_CTRL,
      PER_PREAMBLE,
      PER_GUARD,
      PER_VIDEO
   } period_t;

   localparam int PREAMBLE_LEN_DEF = 8;
   localparam int GUARD_LEN_DEF    = 2;

   // Video guard-band symbols substituted by the serializer mux when GUARD=1
   localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
   localparam logic [9:0] GUARD_CH1 = 10'b0100110011;
   localparam logic [9:0] GUARD_CH2 = 10'b1011001100;

   // {CTL3, CTL2, CTL1, CTL0} during a video data preamble
   localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;

endpackage

// File: rtl/hdmi_period_scheduler_tmds_delay_line.sv
// Fixed-depth shift register with synchronous clear; gives the scheduler its
// look-ahead over the incoming pixel/sync stream.
module tmds_delay_line #(
   parameter int DATA_W = 27,
   parameter int STAGES = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] D,
   output logic [DATA_W-1:0] Q
);

   logic [DATA_W-1:0] sr [STAGES];

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < STAGES; i++) sr[i] <= '0;
      end else begin
         sr[0] <= D;
         for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      end
   end

   assign Q = sr[STAGES-1];

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Delays pixel/sync timing by LOOKAHEAD cycles so the HDMI video preamble and
// guard band can be inserted ahead of each active line on the DVI encoder inputs.
module hdmi_period_scheduler
   import hdmi_period_scheduler_pkg::*;
#(
   parameter int PREAMBLE_LEN = PREAMBLE_LEN_DEF,
   parameter int GUARD_LEN    = GUARD_LEN_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        HDMI_EN,
   input  logic        IN_DE,
   input  logic        IN_HSYNC,
   input  logic        IN_VSYNC,
   input  logic [23:0] IN_RGB,
   output logic        VDE,
   output logic [7:0]  DATA0,
   output logic [7:0]  DATA1,
   output logic [7:0]  DATA2,
   output logic [1:0]  CTRL0,
   output logic [1:0]  CTRL1,
   output logic [1:0]  CTRL2,
   output logic        GUARD,
   output logic        ERR_SHORT_BLANK
);

   localparam int LOOKAHEAD = PREAMBLE_LEN + GUARD_LEN;
   localparam int CNT_W     = $clog2(LOOKAHEAD + 1);
   localparam int BUS_W     = 27;

   logic [BUS_W-1:0] dly_d, dly_q;
   logic             dly_de, dly_vs, dly_hs;
   logic [23:0]      dly_rgb;

   logic             de_prev;
   logic [CNT_W-1:0] blank_cnt;
   logic             blank_full, rise, line_start, line_short;

   period_t          per, per_nxt;
   logic [CNT_W-1:0] phase, phase_nxt;

   logic             vde_d, guard_d;
   logic [1:0]       ctrl1_d, ctrl2_d;

   logic             vde_p0, guard_p0, guard_p1, err_q;
   logic [23:0]      rgb_p0;
   logic [1:0]       ctrl0_p0, ctrl1_p0, ctrl2_p0;

   assign dly_d = {IN_DE, IN_VSYNC, IN_HSYNC, IN_RGB};

   tmds_delay_line #(
      .DATA_W (BUS_W),
      .STAGES (LOOKAHEAD)
   ) u_dly (
      .CLK (CLK),
      .RST (RST),
      .D   (dly_d),
      .Q   (dly_q)
   );

   assign {dly_de, dly_vs, dly_hs, dly_rgb} = dly_q;

   // Input side: rising-edge detect and blanking-length measurement
   assign blank_full = (blank_cnt == CNT_W'(LOOKAHEAD));
   assign rise       = IN_DE & ~de_prev;
   assign line_start = rise & HDMI_EN & blank_full;
   assign line_short = rise & ~blank_full;

   always_ff @(posedge CLK) begin
      if (RST) begin
         de_prev   <= 1'b0;
         blank_cnt <= '0;
         err_q     <= 1'b0;
      end else begin
         de_prev <= IN_DE;
         if (IN_DE)
            blank_cnt <= '0;
         else if (!blank_full)
            blank_cnt <= blank_cnt + CNT_W'(1);
         if (line_short)
            err_q <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         per   <= PER_CTRL;
         phase <= '0;
      end else begin
         per   <= per_nxt;
         phase <= phase_nxt;
      end
   end

   always_comb begin
      per_nxt   = per;
      phase_nxt = phase;
      case (per)
         PER_CTRL: begin
            if (line_start) begin
               per_nxt   = PER_PREAMBLE;
               phase_nxt = CNT_W'(PREAMBLE_LEN - 1);
            end
         end
         PER_PREAMBLE: begin
            if (phase == '0) begin
               per_nxt   = PER_GUARD;
               phase_nxt = CNT_W'(GUARD_LEN - 1);
            end else begin
               phase_nxt = phase - CNT_W'(1);
            end
         end
         PER_GUARD: begin
            if (phase == '0)
               per_nxt = PER_VIDEO;
            else
               phase_nxt = phase - CNT_W'(1);
         end
         PER_VIDEO: begin
            // A new line may start on the very cycle the old one drains out
            if (!dly_de) begin
               if (line_start) begin
                  per_nxt   = PER_PREAMBLE;
                  phase_nxt = CNT_W'(PREAMBLE_LEN - 1);
               end else begin
                  per_nxt = PER_CTRL;
               end
            end
         end
         default: per_nxt = PER_CTRL;
      endcase
   end

   // Overrides keyed on the next period so they line up with the output register
   always_comb begin
      vde_d   = dly_de;
      ctrl1_d = 2'b00;
      ctrl2_d = 2'b00;
      guard_d = 1'b0;
      if (per_nxt == PER_PREAMBLE) begin
         vde_d   = 1'b0;
         ctrl1_d = CTL_VIDEO_PREAMBLE[1:0];
         ctrl2_d = CTL_VIDEO_PREAMBLE[3:2];
      end else if (per_nxt == PER_GUARD) begin
         vde_d   = 1'b0;
         guard_d = 1'b1;
      end
   end

   // Output register stage
   always_ff @(posedge CLK) begin
      if (RST) begin
         vde_p0   <= 1'b0;
         rgb_p0   <= '0;
         ctrl0_p0 <= 2'b00;
         ctrl1_p0 <= 2'b00;
         ctrl2_p0 <= 2'b00;
         guard_p0 <= 1'b0;
         guard_p1 <= 1'b0;
      end else begin
         vde_p0   <= vde_d;
         rgb_p0   <= dly_rgb;
         ctrl0_p0 <= {dly_vs, dly_hs};
         ctrl1_p0 <= ctrl1_d;
         ctrl2_p0 <= ctrl2_d;
         guard_p0 <= guard_d;
         guard_p1 <= guard_p0;
      end
   end

   assign VDE             = vde_p0;
   assign DATA2           = rgb_p0[23:16];
   assign DATA1           = rgb_p0[15:8];
   assign DATA0           = rgb_p0[7:0];
   assign CTRL0           = ctrl0_p0;
   assign CTRL1           = ctrl1_p0;
   assign CTRL2           = ctrl2_p0;
   assign GUARD           = guard_p1;
   assign ERR_SHORT_BLANK = err_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: directed and randomized line timing checked
// every cycle against a history-based model of the scheduling rules.
module tb_hdmi_period_scheduler;

   localparam int LA  = 10;
   localparam int HN  = 8192;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        HDMI_EN = 1'b0;
   logic        IN_DE = 1'b0;
   logic        IN_HSYNC = 1'b0;
   logic        IN_VSYNC = 1'b0;
   logic [23:0] IN_RGB = '0;
   logic        VDE;
   logic [7:0]  DATA0, DATA1, DATA2;
   logic [1:0]  CTRL0, CTRL1, CTRL2;
   logic        GUARD;
   logic        ERR_SHORT_BLANK;

   always #5 CLK = ~CLK;

   hdmi_period_scheduler dut (
      .CLK             (CLK),
      .RST             (RST),
      .HDMI_EN         (HDMI_EN),
      .IN_DE           (IN_DE),
      .IN_HSYNC        (IN_HSYNC),
      .IN_VSYNC        (IN_VSYNC),
      .IN_RGB          (IN_RGB),
      .VDE             (VDE),
      .DATA0           (DATA0),
      .DATA1           (DATA1),
      .DATA2           (DATA2),
      .CTRL0           (CTRL0),
      .CTRL1           (CTRL1),
      .CTRL2           (CTRL2),
      .GUARD           (GUARD),
      .ERR_SHORT_BLANK (ERR_SHORT_BLANK)
   );

   int checks = 0;
   int errors = 0;
   int k = -1;

   // Input history, one entry per clock edge, plus derived line events
   logic        rst_h [HN];
   logic        hen_h [HN];
   logic        de_h  [HN];
   logic        hs_h  [HN];
   logic        vs_h  [HN];
   logic [23:0] rgb_h [HN];
   int          lr_h  [HN];
   logic        start_h [HN];
   logic        short_h [HN];
   logic        err_m = 1'b0;

   function automatic int blank_before(int j);
      int cnt = 0;
      int i = j - 1;
      while (i >= 0 && i > lr_h[j] && !de_h[i] && cnt < LA) begin
         cnt++;
         i--;
      end
      return cnt;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, k);
      end
   endtask

   task automatic check_outputs();
      logic        e_vde = 1'b0;
      logic [23:0] e_rgb = '0;
      logic [1:0]  e_c0 = 2'b00;
      logic [1:0]  e_c1 = 2'b00;
      logic        e_g = 1'b0;
      int b = k - LA;
      if (b > lr_h[k]) begin
         e_vde = de_h[b];
         e_rgb = rgb_h[b];
         e_c0  = {vs_h[b], hs_h[b]};
      end
      for (int t = k - 9; t <= k; t++) begin
         if (t > lr_h[k] && start_h[t]) begin
            e_vde = 1'b0;
            if (k - t <= 7) e_c1 = 2'b01;
         end
      end
      for (int t = k - 10; t <= k - 9; t++)
         if (t > lr_h[k] && start_h[t]) e_g = 1'b1;
      check("vde",   {31'd0, VDE},   {31'd0, e_vde});
      check("data0", {24'd0, DATA0}, {24'd0, e_rgb[7:0]});
      check("data1", {24'd0, DATA1}, {24'd0, e_rgb[15:8]});
      check("data2", {24'd0, DATA2}, {24'd0, e_rgb[23:16]});
      check("ctrl0", {30'd0, CTRL0}, {30'd0, e_c0});
      check("ctrl1", {30'd0, CTRL1}, {30'd0, e_c1});
      check("ctrl2", {30'd0, CTRL2}, 32'd0);
      check("guard", {31'd0, GUARD}, {31'd0, e_g});
      check("err_short_blank", {31'd0, ERR_SHORT_BLANK}, {31'd0, err_m});
   endtask

   task automatic tick();
      logic prev, rise;
      int   bl;
      @(posedge CLK);
      k++;
      rst_h[k] = RST;
      hen_h[k] = HDMI_EN;
      de_h[k]  = IN_DE;
      hs_h[k]  = IN_HSYNC;
      vs_h[k]  = IN_VSYNC;
      rgb_h[k] = IN_RGB;
      lr_h[k]  = (RST || k == 0) ? k : lr_h[k-1];
      prev = (k > 0 && k - 1 > lr_h[k]) ? de_h[k-1] : 1'b0;
      rise = IN_DE && !prev;
      bl   = blank_before(k);
      start_h[k] = !RST && rise && HDMI_EN && (bl == LA);
      short_h[k] = !RST && rise && (bl < LA);
      err_m = RST ? 1'b0 : (err_m | short_h[k]);
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic r, input logic en, input logic de,
                        input logic hs, input logic vs, input logic [23:0] rgb);
      RST = r; HDMI_EN = en; IN_DE = de; IN_HSYNC = hs; IN_VSYNC = vs; IN_RGB = rgb;
      tick();
   endtask

   task automatic blanks(input int n, input logic en, input logic toggle_hs);
      for (int i = 0; i < n; i++)
         drive(1'b0, en, 1'b0, toggle_hs ? i[0] : 1'b0, 1'b0, 24'h000000);
   endtask

   task automatic four_pixels(input logic en);
      drive(1'b0, en, 1'b1, 1'b0, 1'b0, 24'h112233);
      drive(1'b0, en, 1'b1, 1'b0, 1'b0, 24'h223344);
      drive(1'b0, en, 1'b1, 1'b0, 1'b0, 24'h334455);
      drive(1'b0, en, 1'b1, 1'b0, 1'b0, 24'h445566);
   endtask

   initial begin
      // Reset held three cycles, released with DE low
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

      // HDMI line with full blanking: preamble, guard, then pixels
      blanks(20, 1'b1, 1'b0);
      four_pixels(1'b1);
      blanks(20, 1'b1, 1'b0);

      // Same line in DVI mode: plain delayed pass-through
      four_pixels(1'b0);
      blanks(20, 1'b0, 1'b0);

      // Short blanking between two HDMI lines sets the sticky error
      four_pixels(1'b1);
      blanks(6, 1'b1, 1'b0);
      four_pixels(1'b1);
      blanks(25, 1'b1, 1'b0);

      // HSYNC toggling in blanking, then a one-pixel HDMI line
      blanks(30, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 24'hA5C3E1);
      blanks(20, 1'b1, 1'b1);

      // Reset mid-preamble flushes the pipeline
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      blanks(12, 1'b1, 1'b0);
      four_pixels(1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      blanks(20, 1'b1, 1'b0);

      // Randomized lines: blanking length, line length, mode, syncs, pixels, resets
      for (int ln = 0; ln < 60; ln++) begin
         int   nb  = $urandom_range(24, 3);
         int   np  = $urandom_range(12, 1);
         logic en  = 1'($urandom_range(1, 0));
         logic vs  = 1'($urandom_range(1, 0));
         for (int i = 0; i < nb; i++)
            drive(($urandom_range(40, 0) == 0), en, 1'b0,
                  1'($urandom_range(1, 0)), vs, 24'($urandom));
         for (int i = 0; i < np; i++)
            drive(1'b0, ($urandom_range(3, 0) == 0) ? ~en : en, 1'b1,
                  1'b0, vs, 24'($urandom));
      end
      blanks(25, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hdmi_period_scheduler.md
# hdmi_period_scheduler

Sequences the three TMDS channel encoders of the HDMI transmitter. Takes raw pixel and sync timing from the video timing generator and delays it through a fixed pipeline. The delay gives it enough look-ahead to insert the 8-cycle video preamble and 2-cycle video guard band before every active line. Its outputs drive the VDE/VIDDATA/CONTROL inputs of the three DVI encoders, plus a guard-band select that overrides the encoder symbols in the serializer mux.

## Interface
Parameters:
- PREAMBLE_LEN, 8: control-period cycles carrying the video preamble CTL pattern.
- GUARD_LEN, 2: video guard-band cycles.
- LOOKAHEAD, PREAMBLE_LEN+GUARD_LEN: delay-line depth; not overridden independently.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  pixel clock.
- RST  in  1  synchronous, active-high reset.
- HDMI_EN  in  1  1 = HDMI framing (preamble and guard band), 0 = plain DVI.
- IN_DE  in  1  active-video enable from the timing generator.
- IN_HSYNC  in  1  horizontal sync.
- IN_VSYNC  in  1  vertical sync.
- IN_RGB  in  24  pixel: [23:16] R, [15:8] G, [7:0] B.
- VDE  out  1  shared encoder VDE.
- DATA0 / DATA1 / DATA2  out  8 each  B / G / R to encoders 0 / 1 / 2.
- CTRL0 / CTRL1 / CTRL2  out  2 each  encoder CONTROL; CTRL0 = {VSYNC, HSYNC}, CTRL1 = {CTL1, CTL0}, CTRL2 = {CTL3, CTL2}.
- GUARD  out  1  guard-band select, aligned with encoder ENC output.
- ERR_SHORT_BLANK  out  1  sticky; cleared only by RST.

## Operation
- Delay line: LOOKAHEAD stages of {DE, HSYNC, VSYNC, RGB}, then one output register. Reset fills every stage with zeros.
- FSM states, typed period_t: PER_CTRL, PER_PREAMBLE, PER_GUARD, PER_VIDEO.
- Rising-edge detection: a rising edge is IN_DE=1 with previous IN_DE=0.
- Blanking counter: counts consecutive IN_DE=0 cycles, saturating at LOOKAHEAD, and resets to 0 while IN_DE=1.
- PER_CTRL → PER_PREAMBLE: on a rising edge when HDMI_EN=1 and the blanking counter equals LOOKAHEAD.
  - Phase counter loads PREAMBLE_LEN-1.
- Short blanking: a rising edge with blanking counter < LOOKAHEAD stays in PER_CTRL.
  - No preamble or guard band for that line.
  - ERR_SHORT_BLANK ← 1.
- PER_PREAMBLE: counts down to 0, then enters PER_GUARD with phase counter = GUARD_LEN-1.
- PER_GUARD: counts down to 0, then enters PER_VIDEO.
- PER_VIDEO: returns to PER_CTRL when the delayed DE entering the output register is 0.
- Output register, normal case: VDE = delayed DE, DATAn = delayed RGB bytes, CTRL0 = delayed {VSYNC, HSYNC}, CTRL1 = CTRL2 = 00.
- PER_PREAMBLE override: CTRL1 = 01 (CTL0=1, CTL1=0), CTRL2 = 00. VDE is 0 here by construction.
- PER_GUARD override: VDE = 0, CTRL1 = CTRL2 = 00. An internal guard flag is set and registered once more to produce GUARD.
- CTRL0 always carries delayed sync, including during preamble and guard.
- HDMI_EN=0: never leaves PER_CTRL except via PER_VIDEO tracking. Output is pure delayed pass-through and GUARD stays 0.
- HDMI_EN is sampled only at the rising edge; mid-line changes have no effect until the next line.

## Timing
- Reset values: VDE 0, DATA0-2 0x00, CTRL0-2 00, GUARD 0, ERR_SHORT_BLANK 0, state PER_CTRL, blanking counter 0.
- Latency: input at cycle t appears on VDE/DATA/CTRL at cycle t+LOOKAHEAD+1 = t+11. GUARD is one cycle later, matching the encoder's registered ENC.
- Rising edge at cycle t0, HDMI_EN=1, blanking ≥ 10:
  - preamble on CTRL1 during cycles t0+1 … t0+8;
  - guard (VDE=0) during t0+9 … t0+10, with GUARD=1 at t0+10 … t0+11;
  - first pixel with VDE=1 at t0+11.
- One-pixel active line: full preamble and guard, then a single VDE=1 cycle, then PER_CTRL.
- Simultaneous events:
  - RST wins over all activity.
  - RST mid-preamble aborts to PER_CTRL with outputs at reset values next cycle.
  - Counter starts at 0 after reset, so the first line after reset is flagged short unless ≥10 blank cycles precede it.

## Structure
- HDMIPackageSV gains:
  - period_t;
  - PREAMBLE_LEN and GUARD_LEN defaults;
  - guard symbols GUARD_CH0 = 10'b1011001100, GUARD_CH1 = 10'b0100110011, GUARD_CH2 = 10'b1011001100;
  - the preamble CTL constant CTL_VIDEO_PREAMBLE = 4'b0001.
- Sub-module: tmds_delay_line (parameterized width/depth shift register with synchronous clear).

## Test plan
- RST held 3 cycles, then released with IN_DE=0 → all outputs at reset values; ERR_SHORT_BLANK=0.
- 20 blank cycles, then 4 pixels 0x112233…0x445566 with HDMI_EN=1 → CTRL1=01 for 8 cycles, VDE=0 for 2 guard cycles, GUARD=1 one cycle later, VDE=1 with DATA2/1/0 = 11/22/33 at t0+11.
- Same stimulus with HDMI_EN=0 → CTRL1 stays 00, GUARD stays 0, pixels appear at t+11 unchanged.
- Blanking of 6 cycles between lines → no preamble or guard on the second line, ERR_SHORT_BLANK=1 and stays 1 until RST.
- IN_HSYNC toggling during blanking → CTRL0 follows with 11-cycle delay, unaffected by preamble/guard.
- RST asserted at t0+5 (mid-preamble) → next cycle CTRL1=00, VDE=0, GUARD=0, state PER_CTRL; delay line flushed, so no stale pixels emerge.
